// File: rtl/exp_taylor_pipe_pkg.sv
// Shared elaboration-time helpers for the exp(x) Taylor pipeline:
// reciprocal-factorial coefficients and internal datapath sizing.
package exp_taylor_pipe_pkg;

  function automatic longint unsigned factorial(input int unsigned k);
    longint unsigned f;
    f = 64'd1;
    for (int unsigned i = 2; i <= k; i++) f = f * 64'(i);
    return f;
  endfunction

  // RC[k] = round(2^frac_w / k!), ties rounded up.
  function automatic longint unsigned recip_fact(input int unsigned k, input int unsigned frac_w);
    longint unsigned f;
    f = factorial(k);
    return ((64'd1 << frac_w) + (f >> 1)) / f;
  endfunction

  // Wide enough that x^(n_terms-1) in Q.frac_w plus the running sum cannot wrap
  // for any representable x, including the most negative input.
  function automatic int unsigned internal_w(input int unsigned data_w, input int unsigned frac_w,
                                             input int unsigned n_terms, input int unsigned acc_w);
    int unsigned need;
    need = (data_w - frac_w - 1) * (n_terms - 1) + frac_w + 6;
    return (need > acc_w) ? need : acc_w;
  endfunction

  function automatic int unsigned coef_w(input int unsigned frac_w);
    return frac_w + 2;
  endfunction

endpackage

// File: rtl/exp_term_stage.sv
// One registered Taylor term: pow' = pow*x >>> FRAC_W, acc' = acc + (pow'*coef >>> FRAC_W).
// Carries its sample's x alongside so every term uses powers of one input only.
module exp_term_stage
  import exp_taylor_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned IW     = 41,
  parameter int unsigned CW     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv_i,
  input  logic signed [CW-1:0]     coef_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [IW-1:0]     pow_i,
  input  logic signed [IW-1:0]     acc_i,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [IW-1:0]     pow_o,
  output logic signed [IW-1:0]     acc_o
);

  localparam int unsigned PW = IW + DATA_W;
  localparam int unsigned TW = IW + CW;

  logic signed [PW-1:0]     pow_prod;
  logic signed [TW-1:0]     term_prod;
  logic signed [IW-1:0]     pow_d;
  logic signed [IW-1:0]     acc_d;
  logic                     valid_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [IW-1:0]     pow_q;
  logic signed [IW-1:0]     acc_q;

  // Full-width products, then arithmetic shift back to Q.FRAC_W.
  always_comb begin
    pow_prod  = PW'(pow_i) * PW'(x_i);
    pow_d     = IW'(pow_prod >>> FRAC_W);
    term_prod = TW'(pow_d) * TW'(coef_i);
    acc_d     = acc_i + IW'(term_prod >>> FRAC_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      pow_q   <= '0;
      acc_q   <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      x_q     <= x_i;
      pow_q   <= pow_d;
      acc_q   <= acc_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign pow_o   = pow_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/exp_taylor_pipe.sv
// Streaming exp(x) via truncated Taylor series in signed Q.FRAC_W, valid/ready on both
// sides with whole-pipeline stall; result is saturated to [0, 2^(DATA_W-1)-1].
module exp_taylor_pipe
  import exp_taylor_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned N_TERMS = 6,
  parameter int unsigned ACC_W   = 2 * DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_sat_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam int unsigned IW   = internal_w(DATA_W, FRAC_W, N_TERMS, ACC_W);
  localparam int unsigned CW   = coef_w(FRAC_W);
  localparam int unsigned LAST = N_TERMS - 2;

  localparam logic signed [IW-1:0]     ONE     = IW'(1) <<< FRAC_W;
  localparam logic signed [IW-1:0]     SAT_HI  = IW'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic        [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic                     adv;
  logic                     v_w   [N_TERMS-1];
  logic signed [DATA_W-1:0] x_w   [N_TERMS-1];
  logic signed [IW-1:0]     pow_w [N_TERMS-1];
  logic signed [IW-1:0]     acc_w [N_TERMS-1];

  logic [DATA_W-1:0] out_data_d;
  logic              sat_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sat_q;
  logic              out_valid_q;

  assign adv        = !out_valid_q || out_ready_i;
  assign in_ready_o = adv;

  // Term 0/1 are folded combinationally onto the input so latency is N_TERMS-1.
  assign v_w[0]   = in_valid_i;
  assign x_w[0]   = in_data_i;
  assign pow_w[0] = IW'(in_data_i);
  assign acc_w[0] = ONE + IW'(in_data_i);

  for (genvar j = 1; j <= int'(LAST); j++) begin : g_stage
    localparam logic signed [CW-1:0] RC = CW'(recip_fact(j + 1, FRAC_W));
    exp_term_stage #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .IW     (IW),
      .CW     (CW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv_i   (adv),
      .coef_i  (RC),
      .valid_i (v_w[j-1]),
      .x_i     (x_w[j-1]),
      .pow_i   (pow_w[j-1]),
      .acc_i   (acc_w[j-1]),
      .valid_o (v_w[j]),
      .x_o     (x_w[j]),
      .pow_o   (pow_w[j]),
      .acc_o   (acc_w[j])
    );
  end

  // Clamp the final sum into the unsigned range of a signed DATA_W result.
  always_comb begin
    out_data_d = acc_w[LAST][DATA_W-1:0];
    sat_d      = 1'b0;
    if (acc_w[LAST][IW-1]) begin
      out_data_d = '0;
      sat_d      = 1'b1;
    end else if (acc_w[LAST] > SAT_HI) begin
      out_data_d = OUT_MAX;
      sat_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= v_w[LAST];
      out_data_q  <= out_data_d;
      out_sat_q   <= v_w[LAST] & sat_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_exp_taylor_pipe.sv
// Self-checking bench for exp_taylor_pipe: default build plus N_TERMS=4, N_TERMS=2 and 24/16 builds,
// all checked against a wide-integer model of the truncated Taylor series.
module tb_exp_taylor_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  logic        cv;
  logic        c_rdy;
  logic [15:0] c4_d, c4_o, c2_d, c2_o;
  logic [23:0] c24_d, c24_o;
  logic        c4_r, c4_s, c4_v, c2_r, c2_s, c2_v, c24_r, c24_s, c24_v;

  int n_checks = 0;
  int n_fail   = 0;

  exp_taylor_pipe dut (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_sat_o(out_sat), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  exp_taylor_pipe #(.N_TERMS(4)) dut4 (
    .clk(clk), .rst(rst), .in_data_i(c4_d), .in_valid_i(cv), .in_ready_o(c4_r),
    .out_data_o(c4_o), .out_sat_o(c4_s), .out_valid_o(c4_v), .out_ready_i(c_rdy)
  );

  exp_taylor_pipe #(.N_TERMS(2)) dut2 (
    .clk(clk), .rst(rst), .in_data_i(c2_d), .in_valid_i(cv), .in_ready_o(c2_r),
    .out_data_o(c2_o), .out_sat_o(c2_s), .out_valid_o(c2_v), .out_ready_i(c_rdy)
  );

  exp_taylor_pipe #(.DATA_W(24), .FRAC_W(16)) dut24 (
    .clk(clk), .rst(rst), .in_data_i(c24_d), .in_valid_i(cv), .in_ready_o(c24_r),
    .out_data_o(c24_o), .out_sat_o(c24_s), .out_valid_o(c24_v), .out_ready_i(c_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exp(x) ~ sum_{k<nt} x^k/k! evaluated with 128-bit integers, coefficients from reals.
  function automatic void ref_exp(input int dw, input int fw, input int nt, input longint x,
                                  output longint d, output bit s);
    logic signed [127:0] xx, pow, acc, rc, lim;
    real fct;
    xx  = x;
    pow = xx;
    acc = (128'sd1 <<< fw) + xx;
    fct = 1.0;
    for (int k = 2; k < nt; k++) begin
      fct = fct * k;
      rc  = 128'(longint'($floor((2.0 ** fw) / fct + 0.5)));
      pow = (pow * xx) >>> fw;
      acc = acc + ((pow * rc) >>> fw);
    end
    lim = (128'sd1 <<< (dw - 1)) - 1;
    if (acc < 0) begin
      d = 0; s = 1'b1;
    end else if (acc > lim) begin
      d = longint'(lim); s = 1'b1;
    end else begin
      d = longint'(acc); s = 1'b0;
    end
  endfunction

  function automatic longint rand_x();
    logic [15:0] r;
    if ($urandom_range(1) == 0) return longint'($urandom_range(8192)) - 4096;
    r = 16'($urandom);
    return longint'($signed(r));
  endfunction

  task automatic send_one(input longint x, output logic [15:0] d, output logic s, output int lat);
    lat = -1; d = 'x; s = 1'bx;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'(x);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = c; d = out_data; s = out_sat; end
      if (lat < 0) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", out_data); end
    n_checks++;
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", out_sat); end
    n_checks++;
    if ({c4_v, c2_v, c24_v} !== 3'b000) begin n_fail++; $display("FAIL reset_cfg_valid: got %b want 000", {c4_v, c2_v, c24_v}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero();
    logic [15:0] d; logic s; int lat;
    send_one(0, d, s, lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL zero_latency: got %0d want 5", lat); end
    n_checks++;
    if (d !== 16'd1024) begin n_fail++; $display("FAIL zero_data: got %0d want 1024", d); end
    n_checks++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL zero_sat: got %b want 0", s); end
  endtask

  task automatic test_known();
    longint xs[6] = '{1024, -1024, 8192, -32768, 32767, 2048};
    longint near[6] = '{2782, 375, 32767, -1, 32767, -1};
    logic [15:0] d; logic s; int lat; longint md; bit ms; longint diff;
    for (int i = 0; i < 6; i++) begin
      ref_exp(16, 10, 6, xs[i], md, ms);
      send_one(xs[i], d, s, lat);
      n_checks++;
      if (lat !== 5 || d !== 16'(md) || s !== ms)
        begin n_fail++; $display("FAIL known x=%0d: got d=%0d s=%b lat=%0d want d=%0d s=%b lat=5", xs[i], d, s, lat, md, ms); end
      if (near[i] >= 0) begin
        diff = longint'(d) - near[i];
        n_checks++;
        if (diff > 2 || diff < -2) begin n_fail++; $display("FAIL known_near x=%0d: got %0d want %0d+-2", xs[i], d, near[i]); end
      end
    end
    send_one(8192, d, s, lat);
    n_checks++;
    if (d !== 16'd32767 || s !== 1'b1) begin n_fail++; $display("FAIL big_x: got d=%0d s=%b want 32767 1", d, s); end
  endtask

  task automatic run_stream(input int n, input int rdy_pct, input int vld_pct, input bit chk_rdy, input string tag);
    logic [15:0] qd[$];
    bit qs[$];
    int sent = 0, got = 0, cyc = 0;
    bit prev_stall = 1'b0;
    logic [15:0] held_d = '0;
    logic held_s = 1'b0;
    longint x = 0, md;
    bit ms;
    logic [15:0] ed;
    bit es;
    while (got < n && cyc < 20 * n + 100) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (sent < n && $urandom_range(99) < vld_pct) begin
        x = rand_x(); in_valid = 1'b1; in_data = 16'(x);
      end else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_sat !== held_s)
          begin n_fail++; $display("FAIL %s_hold: got v=%b d=%0d s=%b want 1 %0d %b", tag, out_valid, out_data, out_sat, held_d, held_s); end
      end
      if (chk_rdy) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b want 1", tag, in_ready); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (qd.size() == 0) begin
          n_fail++; $display("FAIL %s_extra: got unexpected output d=%0d want none", tag, out_data);
        end else begin
          ed = qd.pop_front(); es = qs.pop_front();
          if (out_data !== ed || out_sat !== es)
            begin n_fail++; $display("FAIL %s_data #%0d: got d=%0d s=%b want d=%0d s=%b", tag, got, out_data, out_sat, ed, es); end
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      held_d = out_data; held_s = out_sat;
      if (in_valid && in_ready === 1'b1) begin
        ref_exp(16, 10, 6, x, md, ms);
        qd.push_back(16'(md)); qs.push_back(ms); sent++;
      end
      @(posedge clk);
      cyc++;
    end
    n_checks++;
    if (got != n) begin n_fail++; $display("FAIL %s_count: got %0d outputs want %0d", tag, got, n); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain: got valid %b want 0", tag, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    run_stream(64, 100, 100, 1'b1, "b2b");
  endtask

  task automatic test_stall_random();
    run_stream(200, 60, 70, 1'b0, "stall");
  endtask

  task automatic test_reset_flush();
    logic [15:0] d; logic s; int lat; longint x, md; bit ms;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'(rand_x());
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin n_fail++; $display("FAIL flush_async: got v=%b d=%0d want 0 0", out_valid, out_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale cycle %0d: got %b want 0", i, out_valid); end
    end
    x = rand_x();
    ref_exp(16, 10, 6, x, md, ms);
    send_one(x, d, s, lat);
    n_checks++;
    if (lat !== 5 || d !== 16'(md) || s !== ms)
      begin n_fail++; $display("FAIL flush_next x=%0d: got d=%0d s=%b lat=%0d want %0d %b 5", x, d, s, lat, md, ms); end
  endtask

  task automatic test_configs();
    real vals[6] = '{0.0, 1.0, -1.0, 8.0, -16.0, 31.0};
    longint x16, x24, md;
    bit ms;
    int l4, l2, l24;
    logic [15:0] d4, d2;
    logic [23:0] d24;
    logic s4, s2, s24;
    for (int i = 0; i < 6; i++) begin
      x16 = longint'($floor(vals[i] * 1024.0 + 0.5));
      x24 = longint'($floor(vals[i] * 65536.0 + 0.5));
      @(negedge clk);
      cv = 1'b1; c4_d = 16'(x16); c2_d = 16'(x16); c24_d = 24'(x24);
      @(posedge clk);
      #1 cv = 1'b0;
      l4 = -1; l2 = -1; l24 = -1;
      d4 = 'x; d2 = 'x; d24 = 'x; s4 = 1'bx; s2 = 1'bx; s24 = 1'bx;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (c4_v === 1'b1 && l4 < 0) begin l4 = c; d4 = c4_o; s4 = c4_s; end
        if (c2_v === 1'b1 && l2 < 0) begin l2 = c; d2 = c2_o; s2 = c2_s; end
        if (c24_v === 1'b1 && l24 < 0) begin l24 = c; d24 = c24_o; s24 = c24_s; end
        @(posedge clk);
      end
      ref_exp(16, 10, 4, x16, md, ms);
      n_checks++;
      if (l4 !== 3 || d4 !== 16'(md) || s4 !== ms)
        begin n_fail++; $display("FAIL n4 x=%0d: got d=%0d s=%b lat=%0d want %0d %b 3", x16, d4, s4, l4, md, ms); end
      ref_exp(16, 10, 2, x16, md, ms);
      n_checks++;
      if (l2 !== 1 || d2 !== 16'(md) || s2 !== ms)
        begin n_fail++; $display("FAIL n2 x=%0d: got d=%0d s=%b lat=%0d want %0d %b 1", x16, d2, s2, l2, md, ms); end
      ref_exp(24, 16, 6, x24, md, ms);
      n_checks++;
      if (l24 !== 5 || d24 !== 24'(md) || s24 !== ms)
        begin n_fail++; $display("FAIL w24 x=%0d: got d=%0d s=%b lat=%0d want %0d %b 5", x24, d24, s24, l24, md, ms); end
    end
    n_checks++;
    if (c4_r !== 1'b1 || c2_r !== 1'b1 || c24_r !== 1'b1)
      begin n_fail++; $display("FAIL cfg_in_ready: got %b%b%b want 111", c4_r, c2_r, c24_r); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cv = 1'b0; c_rdy = 1'b1; c4_d = '0; c2_d = '0; c24_d = '0;
    test_reset();
    test_zero();
    test_known();
    test_back_to_back();
    test_stall_random();
    test_reset_flush();
    test_configs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
